fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined core. It replaces the bare PC register and +4 adder with three pieces: a PC generator, a request/response instruction-memory handshake tolerating arbitrary in-order latency, and a DEPTH-entry prefetch FIFO. It supports stall via `out_ready` and flush/redirect on taken branches or jumps. It sits in front of the fetch/decode pipeline register and feeds it an instruction, its PC and PC+PC_STEP.

---
 rtl/fetch_queue.sv | 149 ++++++++++++++
 tb/tb_fetch_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// PC generator + in-order request/response imem handshake + DEPTH-entry prefetch FIFO.
// Ports:
//   clk, rst (async, active-low)
//   imem_req_valid/ready/addr   : fetch request channel (addr = current PC)
//   imem_resp_valid/data        : in-order instruction returns, never backpressured
//   redirect_valid/redirect_pc  : flush and restart fetch at redirect_pc
//   out_valid/ready/instr/pc/pc_next : head of the prefetch FIFO toward decode
//   occupancy                   : FIFO entry count
module fetch_queue #(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned      PC_STEP  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req_valid,
   input  logic                   imem_req_ready,
   output logic [WIDTH-1:0]       imem_req_addr,
   input  logic                   imem_resp_valid,
   input  logic [WIDTH-1:0]       imem_resp_data,
   input  logic                   redirect_valid,
   input  logic [WIDTH-1:0]       redirect_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_instr,
   output logic [WIDTH-1:0]       out_pc,
   output logic [WIDTH-1:0]       out_pc_next,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int unsigned      PW      = $clog2(DEPTH);
   localparam int unsigned      CW      = PW + 1;
   localparam logic [WIDTH-1:0] STEP    = WIDTH'(PC_STEP);
   localparam logic [CW:0]      DEPTH_X = (CW+1)'(DEPTH);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    outst_q, outst_d;
   logic [CW-1:0]    drop_q, drop_d;
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [PW-1:0]    tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic             active_q, active_d;

   logic [WIDTH-1:0] fifo_instr [DEPTH];
   logic [WIDTH-1:0] fifo_pc    [DEPTH];
   logic [WIDTH-1:0] tag_pc     [DEPTH];

   logic [CW:0] credit_sum;
   logic        req_fire, resp_fire, drop_now, push, pop;

   // Credit check: FIFO entries plus in-flight requests must leave room for every response.
   assign credit_sum     = {1'b0, count_q} + {1'b0, outst_q};
   assign imem_req_valid = active_q && !redirect_valid && (credit_sum < DEPTH_X);
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a protocol error and is ignored.
   assign resp_fire = imem_resp_valid && (outst_q != '0);
   assign drop_now  = resp_fire && (drop_q != '0);
   assign push      = resp_fire && !drop_now && !redirect_valid;

   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign occupancy = count_q;

   // Data outputs are forced to zero while the FIFO is empty, which also covers reset.
   assign out_instr   = out_valid ? fifo_instr[rd_q] : '0;
   assign out_pc      = out_valid ? fifo_pc[rd_q] : '0;
   assign out_pc_next = out_valid ? (fifo_pc[rd_q] + STEP) : '0;

   // Next-state logic; redirect overrides the FIFO, PC and drop counter.
   always_comb begin
      pc_d     = pc_q;
      count_d  = count_q;
      outst_d  = outst_q;
      drop_d   = drop_q;
      wr_d     = wr_q;
      rd_d     = rd_q;
      tag_wr_d = tag_wr_q;
      tag_rd_d = tag_rd_q;
      active_d = 1'b1;

      outst_d = outst_q + CW'(req_fire) - CW'(resp_fire);
      if (req_fire) begin
         pc_d     = pc_q + STEP;
         tag_wr_d = tag_wr_q + PW'(1);
      end
      if (resp_fire) begin
         tag_rd_d = tag_rd_q + PW'(1);
      end

      if (redirect_valid) begin
         pc_d    = redirect_pc;
         count_d = '0;
         wr_d    = '0;
         rd_d    = '0;
         // Every request still in flight after this edge belongs to the old stream.
         drop_d  = outst_d;
      end else begin
         count_d = count_q + CW'(push) - CW'(pop);
         drop_d  = drop_q - CW'(drop_now);
         if (push) begin
            wr_d = wr_q + PW'(1);
         end
         if (pop) begin
            rd_d = rd_q + PW'(1);
         end
      end
   end

   // Control state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= RESET_PC;
         count_q  <= '0;
         outst_q  <= '0;
         drop_q   <= '0;
         wr_q     <= '0;
         rd_q     <= '0;
         tag_wr_q <= '0;
         tag_rd_q <= '0;
         active_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         count_q  <= count_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         tag_wr_q <= tag_wr_d;
         tag_rd_q <= tag_rd_d;
         active_q <= active_d;
      end
   end

   // Storage arrays: FIFO payload and the request-PC tag queue.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_q] <= imem_resp_data;
         fifo_pc[wr_q]    <= tag_pc[tag_rd_q];
      end
      if (req_fire) begin
         tag_pc[tag_wr_q] <= pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed table, corner-case sequences and randomized
// traffic against a queue-based reference model with an in-order latency memory.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid, out_ready;
   logic [31:0] out_instr, out_pc, out_pc_next;
   logic [2:0]  occupancy;

   always #5 clk = ~clk;

   fetch_queue #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RPC), .PC_STEP(4)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_pc_next(out_pc_next),
      .occupancy(occupancy)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mem_q[$];   // accepted requests awaiting a response
   logic [31:0] fifo_m[$];  // PCs the FIFO should hold, head first
   int          drop_m, stepn, last_due, lat_min, lat_max, max_occ;
   logic [31:0] fetch_pc, arch_pc;
   bit          active_m;
   int          n_chk = 0;
   int          n_pass = 0;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h (step %0d)", name, act, exp, stepn);
   endtask

   // One clock of stimulus: drive at negedge, compare, then advance the model across the next edge.
   task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc,
                       input bit rq_rdy, input bit spur);
      bit          resp, exp_rv, pop, fire;
      logic [31:0] hd;
      int          d;
      @(negedge clk);
      resp            = 1'b0;
      hd              = '0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      if (mem_q.size() != 0 && mem_q[0].due <= stepn) begin
         resp            = 1'b1;
         imem_resp_valid = 1'b1;
         imem_resp_data  = instr_of(mem_q[0].addr);
      end else if (spur && mem_q.size() == 0) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = 32'hDEAD_BEEF;
      end
      out_ready      = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_req_ready = rq_rdy;
      #1;
      exp_rv = active_m && !redir && (fifo_m.size() + mem_q.size() < DEPTH);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, fetch_pc);
      chk("occupancy", 32'(occupancy), 32'(fifo_m.size()));
      chk("out_valid", 32'(out_valid), 32'(fifo_m.size() != 0));
      if (fifo_m.size() != 0) begin
         chk("out_pc", out_pc, fifo_m[0]);
         chk("out_instr", out_instr, instr_of(fifo_m[0]));
         chk("out_pc_next", out_pc_next, fifo_m[0] + 32'd4);
      end
      if (32'(occupancy) > max_occ) max_occ = 32'(occupancy);
      pop  = (fifo_m.size() != 0) && rdy;
      fire = imem_req_valid && rq_rdy;
      if (pop) begin
         chk("stream_pc", out_pc, arch_pc);
         arch_pc = arch_pc + 32'd4;
         void'(fifo_m.pop_front());
      end
      if (resp) begin
         hd = mem_q[0].addr;
         void'(mem_q.pop_front());
      end
      if (redir) begin
         fifo_m.delete();
         drop_m   = mem_q.size();
         fetch_pc = rpc;
         arch_pc  = rpc;
      end else begin
         if (resp) begin
            if (drop_m > 0) drop_m--;
            else fifo_m.push_back(hd);
         end
         if (fire) fetch_pc = fetch_pc + 32'd4;
      end
      if (fire) begin
         d = stepn + $urandom_range(lat_max, lat_min);
         if (d < last_due) d = last_due;
         last_due = d;
         mem_q.push_back('{addr: imem_req_addr, due: d});
      end
      stepn++;
   endtask

   // Asynchronous reset mid-cycle; outputs are checked before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_pc_next", out_pc_next, 32'd0);
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      redirect_valid  = 1'b0;
      out_ready       = 1'b0;
      mem_q.delete();
      fifo_m.delete();
      drop_m   = 0;
      last_due = 0;
      fetch_pc = RPC;
      arch_pc  = RPC;
      active_m = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b1;
      active_m = 1'b1;
   endtask

   typedef struct {
      bit          spur;
      bit          exp_rv;
      logic [31:0] exp_addr;
      bit          exp_ov;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl[6];
   bit   found;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      out_ready       = 1'b0;
      stepn = 0; max_occ = 0; lat_min = 1; lat_max = 1;

      // Reset release, 1-cycle memory, decode always ready; first row also sends a stray response.
      tbl[0] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
      tbl[1] = '{1'b0, 1'b1, 32'h104, 1'b0, 32'h0};
      tbl[2] = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h100};
      tbl[3] = '{1'b0, 1'b1, 32'h10C, 1'b1, 32'h104};
      tbl[4] = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h108};
      tbl[5] = '{1'b0, 1'b1, 32'h114, 1'b1, 32'h10C};

      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, '0, 1'b1, tbl[i].spur);
         chk("tbl_req_valid", 32'(imem_req_valid), 32'(tbl[i].exp_rv));
         chk("tbl_req_addr", imem_req_addr, tbl[i].exp_addr);
         chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].exp_ov));
         if (tbl[i].exp_ov) begin
            chk("tbl_out_pc", out_pc, tbl[i].exp_pc);
            chk("tbl_out_pc_next", out_pc_next, tbl[i].exp_pc + 32'd4);
         end
      end

      // Stall with a 2-cycle memory: occupancy saturates, then drains in order.
      lat_min = 2; lat_max = 2; max_occ = 0;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("stall_max_occ", 32'(max_occ), 32'(DEPTH));
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      for (int i = 0; i < 15; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0);

      // Redirect to 0x2000 with three requests in flight on a 3-cycle memory.
      lat_min = 3; lat_max = 3;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (mem_q.size() == 3) found = 1'b1;
         else step(1'b1, 1'b0, '0, 1'b1, 1'b0);
      end
      chk("redir_setup_found", 32'(found), 32'd1);
      step(1'b1, 1'b1, 32'h2000, 1'b1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 1'b0, '0, 1'b1, 1'b0);
         if (out_valid) found = 1'b1;
      end
      chk("redir_first_seen", 32'(found), 32'd1);
      chk("redir_first_pc", out_pc, 32'h2000);
      chk("redir_first_instr", out_instr, instr_of(32'h2000));

      // Redirect, response and pop all in the same cycle.
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (fifo_m.size() > 0 && mem_q.size() >= 2 && mem_q[0].due <= stepn) found = 1'b1;
         else step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      end
      chk("simul_setup_found", 32'(found), 32'd1);
      step(1'b1, 1'b1, 32'h3000, 1'b1, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("simul_flushed_occ", 32'(occupancy), 32'd0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 1'b0, '0, 1'b1, 1'b0);
         if (out_valid) found = 1'b1;
      end
      chk("simul_first_pc", out_pc, 32'h3000);

      // PC wrap-around at the top of the address space.
      lat_min = 1; lat_max = 1;
      step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 1'b0, '0, 1'b1, 1'b0);
         if (out_valid) found = 1'b1;
      end
      chk("wrap_first_pc", out_pc, 32'hFFFF_FFFC);
      chk("wrap_pc_next", out_pc_next, 32'h0000_0000);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset with a loaded FIFO and requests in flight.
      lat_min = 2; lat_max = 2;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
      do_reset();
      step(1'b1, 1'b0, '0, 1'b1, 1'b0);
      chk("post_rst_req_addr", imem_req_addr, RPC);
      chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);

      // Randomized traffic.
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 2000; i++) begin
         logic [31:0] rpc;
         rpc = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
         step($urandom_range(9, 0) < 7, $urandom_range(24, 0) == 0, rpc,
              $urandom_range(9, 0) < 7, $urandom_range(29, 0) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
